// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: PC-unit state encoding and default widths.
package mips_pkg;

  localparam logic RUN  = 1'b0;
  localparam logic HOLD = 1'b1;

  localparam int DEFAULT_DATA_W      = 32;
  localparam int DEFAULT_ALIGN_SHIFT = 2;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target generator: sequential, branch, jump and
// jump-register targets plus the priority select between them.
module pc_target_calc
  import mips_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int JADDR_W     = 26,
  parameter int IMM_W       = 16,
  parameter int ALIGN_SHIFT = DEFAULT_ALIGN_SHIFT,
  parameter int JUMP_MODE   = 1
) (
  input  logic [DATA_W-1:0]  pc,
  input  logic               branch_taken,
  input  logic [IMM_W-1:0]   branch_imm,
  input  logic               jump,
  input  logic [JADDR_W-1:0] jump_addr,
  input  logic               jump_reg,
  input  logic [DATA_W-1:0]  reg_target,
  output logic [DATA_W-1:0]  pc_plus4,
  output logic [DATA_W-1:0]  target,
  output logic               redirect,
  output logic               jr_misaligned
);

  localparam logic [DATA_W-1:0] STEP        = DATA_W'(1) << ALIGN_SHIFT;
  localparam logic [DATA_W-1:0] ALIGN_MASK  = STEP - DATA_W'(1);
  // Low bits replaced by the J-type field; everything above comes from pc_plus4.
  localparam logic [DATA_W-1:0] REGION_MASK =
    (DATA_W'(1) << (JADDR_W + ALIGN_SHIFT)) - DATA_W'(1);

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] br_tgt;
  logic [DATA_W-1:0] j_tgt;
  logic [DATA_W-1:0] jr_tgt;

  assign pc_plus4 = pc + STEP;
  assign imm_sext = {{(DATA_W-IMM_W){branch_imm[IMM_W-1]}}, branch_imm};
  assign br_tgt   = pc_plus4 + (imm_sext << ALIGN_SHIFT);
  assign jr_tgt   = reg_target & ~ALIGN_MASK;
  assign redirect = jump_reg | jump | branch_taken;
  assign jr_misaligned = jump_reg & ((reg_target & ALIGN_MASK) != {DATA_W{1'b0}});

  generate
    if (JUMP_MODE == 0) begin : g_jmp_legacy
      assign j_tgt = DATA_W'(jump_addr);
    end else begin : g_jmp_region
      assign j_tgt = (pc_plus4 & ~REGION_MASK) | (DATA_W'(jump_addr) << ALIGN_SHIFT);
    end
  endgenerate

  // Priority select: jump_reg > jump > branch_taken > sequential.
  always_comb begin
    target = pc_plus4;
    if (jump_reg) begin
      target = jr_tgt;
    end else if (jump) begin
      target = j_tgt;
    end else if (branch_taken) begin
      target = br_tgt;
    end else begin
      target = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_target_unit.sv
// Registered program counter with stall hold and single-entry redirect replay.
module pc_target_unit
  import mips_pkg::*;
#(
  parameter int                 DATA_W       = DEFAULT_DATA_W,
  parameter int                 JADDR_W      = 26,
  parameter int                 IMM_W        = 16,
  parameter int                 ALIGN_SHIFT  = DEFAULT_ALIGN_SHIFT,
  parameter logic [DATA_W-1:0]  RESET_VECTOR = {DATA_W{1'b0}},
  parameter int                 JUMP_MODE    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [IMM_W-1:0]   branch_imm,
  input  logic               jump,
  input  logic [JADDR_W-1:0] jump_addr,
  input  logic               jump_reg,
  input  logic [DATA_W-1:0]  reg_target,
  output logic [DATA_W-1:0]  pc,
  output logic [DATA_W-1:0]  pc_plus4,
  output logic               redirect_pending,
  output logic               misaligned
);

  logic              state;
  logic [DATA_W-1:0] pend_tgt;
  logic [DATA_W-1:0] target;
  logic              redirect;
  logic              jr_misaligned;

  pc_target_calc #(
    .DATA_W      (DATA_W),
    .JADDR_W     (JADDR_W),
    .IMM_W       (IMM_W),
    .ALIGN_SHIFT (ALIGN_SHIFT),
    .JUMP_MODE   (JUMP_MODE)
  ) u_calc (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_imm    (branch_imm),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .pc_plus4      (pc_plus4),
    .target        (target),
    .redirect      (redirect),
    .jr_misaligned (jr_misaligned)
  );

  assign redirect_pending = (state == HOLD);

  // PC / pending-redirect state machine; misaligned is flagged only on first acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      pend_tgt   <= {DATA_W{1'b0}};
      state      <= RUN;
      misaligned <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          misaligned <= jr_misaligned;
          if (!stall) begin
            pc <= target;
          end else if (redirect) begin
            pend_tgt <= target;
            state    <= HOLD;
          end
        end
        HOLD: begin
          misaligned <= 1'b0;
          if (!stall) begin
            pc    <= pend_tgt;
            state <= RUN;
          end
        end
        default: begin
          misaligned <= 1'b0;
          state      <= RUN;
        end
      endcase
    end
  end

endmodule
